// File: rtl/RISCV_pkg.sv
`default_nettype none
// ============================================================================
// Module      : RISCV_pkg
// Description : Shared types and constants for the 5-stage RISC-V pipeline.
//               Fetch-stage additions: fetch FSM state type and the NOP
//               bubble used to fill invalid IF/ID slots.
// Revision    : 1.0 - initial release
// ============================================================================
package RISCV_pkg;

  typedef logic [31:0] word_t;

  // Instruction-fetch handshake states.
  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    KILL = 2'd3
  } fetch_state_t;

  // addi x0,x0,0 : a harmless I-type with a zero immediate.
  localparam word_t NOP_INSTR = 32'h0000_0013;

endpackage
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : Instruction-fetch stage plus IF/ID pipeline register.
//               Single-outstanding request/response fetch from instruction
//               memory, one-entry hold buffer for decode stalls, flush and
//               refetch on taken branch/jump redirects.
// Ports       : clk, rst            - clock, async active-high reset
//               stall_2             - decode cannot accept (hold IF/ID)
//               redirect/redirect_pc- flush and refetch from new PC
//               imem_req/imem_addr  - fetch request (Moore outputs)
//               imem_gnt            - request accepted
//               imem_rvalid/rdata   - fetch response
//               Instruction_2/PC_2/valid_2 - IF/ID register to decode
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage
  import RISCV_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_2,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output word_t       Instruction_2,
  output logic [31:0] PC_2,
  output logic        valid_2
);

  fetch_state_t state;
  logic [31:0]  fetch_pc;
  logic [31:0]  pend_pc;
  word_t        hold_instr;
  logic [31:0]  hold_pc;

  // Low two bits of the redirect target are ignored: fetches are word aligned.
  logic [31:0] redirect_target;
  assign redirect_target = redirect_pc & ~32'h0000_0003;

  // Moore request outputs; suppressed while reset is held.
  assign imem_req  = (state == REQ) && !rst;
  assign imem_addr = fetch_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= REQ;
      fetch_pc      <= RESET_PC;
      pend_pc       <= RESET_PC;
      hold_instr    <= NOP_INSTR;
      hold_pc       <= RESET_PC;
      Instruction_2 <= NOP_INSTR;
      PC_2          <= RESET_PC;
      valid_2       <= 1'b0;
    end else if (redirect) begin
      // Flush beats stall; PC_2 is left as-is. Leaving HOLD drops the buffer.
      fetch_pc      <= redirect_target;
      Instruction_2 <= NOP_INSTR;
      valid_2       <= 1'b0;
      case (state)
        REQ:     state <= imem_gnt ? KILL : REQ;
        WAIT:    state <= imem_rvalid ? REQ : KILL;
        HOLD:    state <= REQ;
        KILL:    state <= imem_rvalid ? REQ : KILL;
        default: state <= REQ;
      endcase
    end else begin
      // Drain to a bubble whenever decode accepts and nothing new arrives;
      // the loads below override this default.
      if (!stall_2) begin
        Instruction_2 <= NOP_INSTR;
        valid_2       <= 1'b0;
      end
      case (state)
        REQ: begin
          if (imem_gnt) begin
            pend_pc  <= fetch_pc;
            fetch_pc <= fetch_pc + 32'd4;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (!stall_2) begin
              Instruction_2 <= imem_rdata;
              PC_2          <= pend_pc;
              valid_2       <= 1'b1;
              state         <= REQ;
            end else begin
              hold_instr <= imem_rdata;
              hold_pc    <= pend_pc;
              state      <= HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall_2) begin
            Instruction_2 <= hold_instr;
            PC_2          <= hold_pc;
            valid_2       <= 1'b1;
            state         <= REQ;
          end
        end
        KILL: begin
          // The squashed response is consumed and dropped.
          if (imem_rvalid) begin
            state <= REQ;
          end
        end
        default: state <= REQ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_stage
// Description : Directed self-checking bench for if_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage;
  import RISCV_pkg::*;

  logic        clk;
  logic        rst;
  logic        stall_2;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  word_t       Instruction_2;
  logic [31:0] PC_2;
  logic        valid_2;

  int n_vec;
  int n_err;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_2       (stall_2),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .Instruction_2 (Instruction_2),
    .PC_2          (PC_2),
    .valid_2       (valid_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic g, input logic rv, input logic [31:0] rd,
                       input logic st, input logic re, input logic [31:0] rpc);
    imem_gnt    = g;
    imem_rvalid = rv;
    imem_rdata  = rd;
    stall_2     = st;
    redirect    = re;
    redirect_pc = rpc;
  endtask

  task automatic chk_if(input string tag, input logic [31:0] ins,
                        input logic [31:0] pc, input logic v);
    chk({tag, "_instr"}, Instruction_2, ins);
    chk({tag, "_pc"},    PC_2, pc);
    chk({tag, "_valid"}, {31'd0, valid_2}, {31'd0, v});
  endtask

  task automatic chk_req(input string tag, input logic r, input logic [31:0] a);
    chk({tag, "_req"}, {31'd0, imem_req}, {31'd0, r});
    if (r) chk({tag, "_addr"}, imem_addr, a);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    step();
    step();
    // Reset state
    chk_req("rst", 1'b0, 32'h0);
    chk_if("rst", NOP_INSTR, 32'h0, 1'b0);

    // Release: request at 0x0 combinationally
    rst = 1'b0;
    #1;
    chk_req("rel", 1'b1, 32'h0);

    // Fetch 0x0
    drive(1, 0, 32'h0, 0, 0, 32'h0); step();
    chk_req("w0", 1'b0, 32'h0);
    drive(0, 1, 32'hAAAA_0001, 0, 0, 32'h0); step();
    chk_if("f0", 32'hAAAA_0001, 32'h0, 1'b1);
    chk_req("r4", 1'b1, 32'h4);

    // Grant 0x4; IF/ID drains to a bubble
    drive(1, 0, 32'h0, 0, 0, 32'h0); step();
    chk_if("drain", NOP_INSTR, 32'h0, 1'b0);
    chk_req("w4", 1'b0, 32'h0);

    // Response for 0x4 under a 4-cycle stall -> HOLD
    drive(0, 1, 32'hBBBB_0004, 1, 0, 32'h0); step();
    chk_if("hold0", NOP_INSTR, 32'h0, 1'b0);
    chk_req("hold0", 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 32'h0, 1, 0, 32'h0); step();
      chk_req("holdn", 1'b0, 32'h0);
    end
    drive(0, 0, 32'h0, 0, 0, 32'h0); step();
    chk_if("unhold", 32'hBBBB_0004, 32'h4, 1'b1);
    chk_req("r8", 1'b1, 32'h8);

    // Redirect coincident with grant of 0x8 -> KILL, refetch at 0x200
    drive(1, 0, 32'h0, 0, 1, 32'h0000_0200); step();
    chk_if("rdg", NOP_INSTR, 32'h4, 1'b0);
    chk_req("rdg", 1'b0, 32'h0);
    drive(0, 0, 32'h0, 0, 0, 32'h0); step();
    chk_req("kill", 1'b0, 32'h0);
    drive(0, 1, 32'hDEAD_0008, 0, 0, 32'h0); step();
    chk_if("kdisc", NOP_INSTR, 32'h4, 1'b0);
    chk_req("r200", 1'b1, 32'h200);

    // Fetch 0x200, then hold it under stall while 0x204 is in WAIT
    drive(1, 0, 32'h0, 0, 0, 32'h0); step();
    drive(0, 1, 32'hCCCC_0200, 0, 0, 32'h0); step();
    chk_if("f200", 32'hCCCC_0200, 32'h200, 1'b1);
    drive(1, 0, 32'h0, 1, 0, 32'h0); step();
    chk_if("stallhold", 32'hCCCC_0200, 32'h200, 1'b1);

    // Redirect in WAIT with stall asserted: flush wins, target 0x103 -> 0x100
    drive(0, 0, 32'h0, 1, 1, 32'h0000_0103); step();
    chk_if("rdw", NOP_INSTR, 32'h200, 1'b0);
    chk_req("rdw", 1'b0, 32'h0);
    drive(0, 1, 32'hDEAD_0204, 0, 0, 32'h0); step();
    chk_if("kdisc2", NOP_INSTR, 32'h200, 1'b0);
    chk_req("r100", 1'b1, 32'h100);

    // Ungranted redirect in REQ to 0xFFFFFFFF -> request at 0xFFFFFFFC
    drive(0, 0, 32'h0, 0, 1, 32'hFFFF_FFFF); step();
    chk_req("rtop", 1'b1, 32'hFFFF_FFFC);
    drive(1, 0, 32'h0, 0, 0, 32'h0); step();
    drive(0, 1, 32'hEEEE_FFFC, 0, 0, 32'h0); step();
    chk_if("ftop", 32'hEEEE_FFFC, 32'hFFFF_FFFC, 1'b1);
    chk_req("wrap", 1'b1, 32'h0);

    // Grant 0x0 with stall so IF/ID stays valid in WAIT, then async reset
    drive(1, 0, 32'h0, 1, 0, 32'h0); step();
    chk_if("prerst", 32'hEEEE_FFFC, 32'hFFFF_FFFC, 1'b1);
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    chk_if("arst", NOP_INSTR, 32'h0, 1'b0);
    chk_req("arst", 1'b0, 32'h0);
    step();
    chk_req("arst2", 1'b0, 32'h0);
    rst = 1'b0;
    #1;
    chk_req("rel2", 1'b1, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
